// File: rtl/memory_access.sv
// memory_access: pipeline MEM stage. Runs the data-memory request/response
// handshake for loads and stores and stalls the pipeline until the response.
// Store data is aligned onto byte lanes. Load data is extracted and extended.
// Results are registered into MEM/WB.
// Ports:
//   clk, rst (async, active low)
//   EX/MEM in : ctrl_word_in, instruction_in, PC_in, alu_in, rs2_in,
//               br_en_in, mem_byte_enable_in
//   stall_in  : global freeze;  stall_out : freeze upstream stages
//   dmem_*    : data-memory request (read/write/address/wdata/byte_enable)
//               and response (rdata/resp)
//   MEM/WB out: ctrl_word_out, instruction_out, PC_out, alu_out, br_en_out,
//               load_data_out
module memory_access #(
    parameter int XLEN            = 32,
    parameter bit BUBBLE_ON_STALL = 1'b1,
    parameter int CTRL_W          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CTRL_W-1:0] ctrl_word_in,
    input  logic [XLEN-1:0]   instruction_in,
    input  logic [XLEN-1:0]   PC_in,
    input  logic [XLEN-1:0]   alu_in,
    input  logic [XLEN-1:0]   rs2_in,
    input  logic              br_en_in,
    input  logic [3:0]        mem_byte_enable_in,
    input  logic              stall_in,
    output logic              stall_out,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [XLEN-1:0]   dmem_address,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_byte_enable,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_resp,
    output logic [CTRL_W-1:0] ctrl_word_out,
    output logic [XLEN-1:0]   instruction_out,
    output logic [XLEN-1:0]   PC_out,
    output logic [XLEN-1:0]   alu_out,
    output logic              br_en_out,
    output logic [XLEN-1:0]   load_data_out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] hold_q, hold_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_load, is_store, mem_op;
    logic            in_done;
    logic [4:0]      sh;
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ext;
    logic            wb_load, wb_bubble;

    assign opcode   = instruction_in[6:0];
    assign funct3   = instruction_in[14:12];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign mem_op   = is_load | is_store;
    assign in_done  = (state_q == DONE);
    assign sh       = {alu_in[1:0], 3'b000};

    // Request and stall are gated by rst so they drop the moment reset
    // asserts, even while EX/MEM still shows a memory op.
    assign dmem_read  = rst & is_load & ~in_done;
    assign dmem_write = rst & is_store & ~in_done;
    assign stall_out  = rst & mem_op & ~in_done & ~dmem_resp;

    assign dmem_address     = rst ? {alu_in[XLEN-1:2], 2'b00} : '0;
    assign dmem_wdata       = rst ? (rs2_in << sh) : '0;
    assign dmem_byte_enable = rst ? mem_byte_enable_in : 4'b0000;

    // After a response captured under freeze, the live bus is stale.
    assign raw = (in_done ? hold_q : dmem_rdata) >> sh;

    always_comb begin
        ext = raw;
        unique case (funct3)
            3'b000:  ext = {{(XLEN-8){raw[7]}}, raw[7:0]};
            3'b001:  ext = {{(XLEN-16){raw[15]}}, raw[15:0]};
            3'b100:  ext = {{(XLEN-8){1'b0}}, raw[7:0]};
            3'b101:  ext = {{(XLEN-16){1'b0}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        unique case (state_q)
            IDLE: begin
                // A stray response with no memory op is ignored here.
                if (mem_op) begin
                    if (!dmem_resp) begin
                        state_d = BUSY;
                    end else if (stall_in) begin
                        state_d = DONE;
                        hold_d  = dmem_rdata;
                    end
                end
            end
            BUSY: begin
                if (!mem_op) begin
                    state_d = IDLE;
                end else if (dmem_resp) begin
                    if (stall_in) begin
                        state_d = DONE;
                        hold_d  = dmem_rdata;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                if (!stall_in) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign wb_load   = ~stall_in & ~stall_out;
    assign wb_bubble = BUBBLE_ON_STALL & stall_out & ~stall_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_word_out   <= '0;
            instruction_out <= '0;
            PC_out          <= '0;
            alu_out         <= '0;
            br_en_out       <= 1'b0;
            load_data_out   <= '0;
        end else if (wb_load) begin
            ctrl_word_out   <= ctrl_word_in;
            instruction_out <= instruction_in;
            PC_out          <= PC_in;
            alu_out         <= alu_in;
            br_en_out       <= br_en_in;
            load_data_out   <= is_load ? ext : '0;
        end else if (wb_bubble) begin
            ctrl_word_out   <= '0;
            instruction_out <= '0;
            PC_out          <= '0;
            alu_out         <= '0;
            br_en_out       <= 1'b0;
            load_data_out   <= '0;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed and randomized checks of the MEM stage
// against a behavioural model of the memory handshake and MEM/WB contents.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl_word_in, instruction_in, PC_in, alu_in, rs2_in;
    logic        br_en_in;
    logic [3:0]  mem_byte_enable_in;
    logic        stall_in;
    logic        stall_out, dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] ctrl_word_out, instruction_out, PC_out, alu_out;
    logic        br_en_out;
    logic [31:0] load_data_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] e_ctrl, e_ins, e_pc, e_alu, e_ld;
    logic        e_br;

    memory_access dut (
        .clk(clk), .rst(rst),
        .ctrl_word_in(ctrl_word_in), .instruction_in(instruction_in),
        .PC_in(PC_in), .alu_in(alu_in), .rs2_in(rs2_in),
        .br_en_in(br_en_in), .mem_byte_enable_in(mem_byte_enable_in),
        .stall_in(stall_in), .stall_out(stall_out),
        .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
        .dmem_byte_enable(dmem_byte_enable),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .ctrl_word_out(ctrl_word_out), .instruction_out(instruction_out),
        .PC_out(PC_out), .alu_out(alu_out), .br_en_out(br_en_out),
        .load_data_out(load_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op,
                                       input logic [2:0] f3);
        return {17'h0, f3, 5'd1, op};
    endfunction

    // Reference load: shift the word down by the byte offset, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] w,
                                             input logic [1:0] off);
        logic [31:0] r;
        r = w >> (8 * off);
        case (f3)
            3'd0:    return int'(byte'(r[7:0]));
            3'd1:    return int'(shortint'(r[15:0]));
            3'd4:    return {24'h0, r[7:0]};
            3'd5:    return {16'h0, r[15:0]};
            default: return r;
        endcase
    endfunction

    task automatic set_exp(input logic [31:0] c, i, p, a, l, input logic b);
        e_ctrl = c; e_ins = i; e_pc = p; e_alu = a; e_ld = l; e_br = b;
    endtask

    task automatic check_wb(input string tag);
        chk({tag, ".ctrl"}, ctrl_word_out, e_ctrl);
        chk({tag, ".ins"}, instruction_out, e_ins);
        chk({tag, ".pc"}, PC_out, e_pc);
        chk({tag, ".alu"}, alu_out, e_alu);
        chk({tag, ".br"}, br_en_out, e_br);
        chk({tag, ".ld"}, load_data_out, e_ld);
    endtask

    // One EX/MEM op. lat: cycles before the response (0 = same cycle).
    // stl: hold stall_in high through the response and 'extra' more cycles.
    task automatic run_op(input logic [31:0] ctrl, ins, pc, alu, rs2,
                          input logic br, input logic [3:0] be,
                          input int lat, input int extra, input logic stl,
                          input logic [31:0] rd);
        logic        ld, st, mem;
        logic [31:0] eld, ew;
        ld  = (ins[6:0] == 7'b0000011);
        st  = (ins[6:0] == 7'b0100011);
        mem = ld | st;
        if (!mem) lat = 0;
        eld = ld ? ref_load(ins[14:12], rd, alu[1:0]) : 32'h0;
        ew  = rs2 << (8 * alu[1:0]);
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            ctrl_word_in = ctrl; instruction_in = ins; PC_in = pc;
            alu_in = alu; rs2_in = rs2; br_en_in = br;
            mem_byte_enable_in = be; stall_in = stl;
            dmem_resp  = mem && (k == lat);
            dmem_rdata = (mem && (k == lat)) ? rd : $urandom;
            #1;
            chk("req.rd", dmem_read, ld);
            chk("req.wr", dmem_write, st);
            chk("req.stall", stall_out, mem && (k < lat));
            if (mem) begin
                chk("req.addr", dmem_address, alu & ~32'h3);
                chk("req.wdata", dmem_wdata, ew);
                chk("req.be", dmem_byte_enable, be);
            end
            @(posedge clk); #1;
            if (!stl) begin
                if (k < lat) set_exp(0, 0, 0, 0, 0, 0);
                else set_exp(ctrl, ins, pc, alu, eld, br);
            end
            check_wb("wb1");
        end
        if (stl) begin
            for (int j = 0; j <= extra; j++) begin
                @(negedge clk);
                dmem_resp  = 1'b0;
                dmem_rdata = $urandom;
                stall_in   = (j < extra);
                #1;
                chk("done.rd", dmem_read, 0);
                chk("done.wr", dmem_write, 0);
                chk("done.stall", stall_out, 0);
                @(posedge clk); #1;
                if (j == extra) set_exp(ctrl, ins, pc, alu, eld, br);
                check_wb("wb2");
            end
        end
    endtask

    logic [31:0] r_ins;
    logic [2:0]  r_f3;
    int          kind;

    initial begin
        rst = 1'b0;
        ctrl_word_in = 0; instruction_in = 0; PC_in = 0; alu_in = 0;
        rs2_in = 0; br_en_in = 0; mem_byte_enable_in = 0;
        stall_in = 0; dmem_rdata = 0; dmem_resp = 0;
        set_exp(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_wb("rst");
        chk("rst.rd", dmem_read, 0);
        chk("rst.stall", stall_out, 0);
        @(negedge clk);
        rst = 1'b1;

        // lw with response in the third request cycle
        run_op(32'hC0, mk(7'h03, 3'd2), 32'h1000, 32'h100, 0, 0,
               4'hF, 2, 0, 0, 32'hDEADBEEF);
        chk("t1.ld", load_data_out, 32'hDEADBEEF);
        // lb / lbu / lhu
        run_op(32'hC1, mk(7'h03, 3'd0), 32'h1004, 32'h103, 0, 0,
               4'h8, 1, 0, 0, 32'h80123456);
        chk("t2.lb", load_data_out, 32'hFFFFFF80);
        run_op(32'hC2, mk(7'h03, 3'd4), 32'h1008, 32'h103, 0, 0,
               4'h8, 0, 0, 0, 32'h80123456);
        chk("t2.lbu", load_data_out, 32'h00000080);
        run_op(32'hC3, mk(7'h03, 3'd5), 32'h100C, 32'h102, 0, 0,
               4'hC, 1, 0, 0, 32'hBEEF1234);
        chk("t2.lhu", load_data_out, 32'h0000BEEF);
        // sb to lane 1
        run_op(32'hC4, mk(7'h23, 3'd0), 32'h1010, 32'h201, 32'hAB, 1,
               4'b0010, 1, 0, 0, 32'h0);
        chk("t3.ld", load_data_out, 32'h0);
        // lw answered under freeze, freeze held 3 more cycles
        run_op(32'hC5, mk(7'h03, 3'd2), 32'h1014, 32'h300, 0, 0,
               4'hF, 1, 3, 1, 32'h12345678);
        chk("t4.ld", load_data_out, 32'h12345678);
        // add, lw (zero latency), add back to back
        run_op(32'hC6, mk(7'h33, 3'd0), 32'h1018, 32'h11, 0, 1,
               4'h0, 0, 0, 0, 0);
        run_op(32'hC7, mk(7'h03, 3'd2), 32'h101C, 32'h400, 0, 0,
               4'hF, 0, 0, 0, 32'hCAFEF00D);
        run_op(32'hC8, mk(7'h13, 3'd0), 32'h1020, 32'h22, 0, 0,
               4'h0, 0, 0, 0, 0);

        // reset while BUSY (freeze held so MEM/WB is not bubbled first)
        @(negedge clk);
        ctrl_word_in = 32'hD0; instruction_in = mk(7'h03, 3'd2);
        PC_in = 32'h2000; alu_in = 32'h500; stall_in = 1'b1;
        dmem_resp = 1'b0;
        @(posedge clk); #1;
        check_wb("busy");
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("r6.rd", dmem_read, 0);
        chk("r6.stall", stall_out, 0);
        set_exp(0, 0, 0, 0, 0, 0);
        check_wb("r6");
        ctrl_word_in = 0; instruction_in = 0; PC_in = 0; alu_in = 0;
        stall_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        dmem_resp = 1'b1; dmem_rdata = 32'hBAD0BAD0;
        #1;
        chk("late.rd", dmem_read, 0);
        chk("late.stall", stall_out, 0);
        @(posedge clk); #1;
        check_wb("late");
        run_op(32'hD1, mk(7'h03, 3'd2), 32'h2004, 32'h504, 0, 0,
               4'hF, 1, 0, 0, 32'h0F0F0F0F);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                r_f3  = 3'($urandom_range(0, 7));
                r_ins = mk(7'h03, r_f3);
            end else if (kind == 1) begin
                r_f3  = 3'($urandom_range(0, 2));
                r_ins = mk(7'h23, r_f3);
            end else begin
                r_ins = mk($urandom_range(0, 1) ? 7'h33 : 7'h13, 3'd0);
            end
            r_ins[31:25] = 7'($urandom);
            run_op($urandom, r_ins, $urandom, $urandom, $urandom,
                   1'($urandom), 4'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 2), ($urandom_range(0, 3) == 0),
                   $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
